// File: rtl/sawtooth_keystream.sv
// Multi-channel sawtooth chaotic map keystream: x <= frac(g*x) per channel, word = XOR of state MSBs.
// Output is registered state (no extra latency); stalls hold state. Optional LFSR perturbation: SAWTOOTH_PERTURB_EN.
module sawtooth_keystream #(
  parameter int FRAC_W   = 32,
  parameter int GAIN_W   = 16,
  parameter int CHANNELS = 2,
  parameter int N_WARMUP = 64,
  parameter int OUT_W    = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 seed_valid,
  output logic                                 seed_ready,
  input  logic [CHANNELS*FRAC_W-1:0]           seed_x,
  input  logic [CHANNELS*(GAIN_W+FRAC_W)-1:0]  seed_gain,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [OUT_W-1:0]                     out_data,
  output logic                                 busy,
  output logic                                 degen
);

  localparam int GW    = GAIN_W + FRAC_W;
  localparam int PW    = 2 * FRAC_W + GAIN_W;
  localparam int CNT_W = (N_WARMUP > 1) ? $clog2(N_WARMUP) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((N_WARMUP > 0) ? N_WARMUP - 1 : 0);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WARMUP = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;

  logic [1:0]                      state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [CHANNELS-1:0][FRAC_W-1:0] x_q, x_d, iter_x, run_x;
  logic [CHANNELS-1:0][GW-1:0]     g_q, g_d;
  logic [PW-1:0]                   prod;
  logic                            seed_acc;
  logic                            any_zero;

  // Full-width product, then keep only the fractional half: integer part wraps away.
  always_comb begin
    prod   = '0;
    iter_x = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      prod      = PW'(x_q[c]) * PW'(g_q[c]);
      iter_x[c] = FRAC_W'(prod >> FRAC_W);
    end
  end

`ifdef SAWTOOTH_PERTURB_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr_q, lfsr_d;

  function automatic logic [15:0] rotl16(input logic [15:0] v, input int unsigned n);
    return (v << n) | (v >> (16 - n));
  endfunction

  always_comb begin
    run_x = iter_x;
    for (int c = 0; c < CHANNELS; c++) begin
      run_x[c][15:0] = iter_x[c][15:0] ^ rotl16(lfsr_q, c % 16);
    end
  end
`else
  assign run_x = iter_x;
`endif

  assign seed_ready = (state_q != WARMUP);
  assign out_valid  = (state_q == RUN);
  assign busy       = (state_q == WARMUP);

  always_comb begin
    seed_acc = seed_valid && seed_ready;
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    g_d      = g_q;
`ifdef SAWTOOTH_PERTURB_EN
    lfsr_d   = lfsr_q;
`endif
    // A seed wins over a concurrent RUN iteration; the presented word still counts as taken.
    if (seed_acc) begin
      x_d     = seed_x;
      g_d     = seed_gain;
      cnt_d   = CNT_INIT;
      state_d = (N_WARMUP == 0) ? RUN : WARMUP;
`ifdef SAWTOOTH_PERTURB_EN
      lfsr_d  = LFSR_SEED;
`endif
    end else begin
      case (state_q)
        WARMUP: begin
          x_d = iter_x;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - 1'b1;
        end
        RUN: begin
          if (out_ready) begin
            x_d = run_x;
`ifdef SAWTOOTH_PERTURB_EN
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    out_data = '0;
    any_zero = 1'b0;
    for (int c = 0; c < CHANNELS; c++) begin
      out_data = out_data ^ x_q[c][FRAC_W-1 -: OUT_W];
      if (x_q[c] == '0) any_zero = 1'b1;
    end
    degen = out_valid && any_zero;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      g_q     <= '0;
`ifdef SAWTOOTH_PERTURB_EN
      lfsr_q  <= LFSR_SEED;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      g_q     <= g_d;
`ifdef SAWTOOTH_PERTURB_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

endmodule

// File: tb/tb_sawtooth_keystream.sv
// Bench for sawtooth_keystream: three parameterisations checked against a spec-level model.
module tb_sawtooth_keystream;

`ifdef SAWTOOTH_PERTURB_EN
  localparam bit PERTURB = 1'b1;
`else
  localparam bit PERTURB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int tests_run = 0;
  int tests_failed = 0;

  // u1: CHANNELS=1, N_WARMUP=1
  logic a_seed_valid, a_seed_ready, a_out_valid, a_out_ready, a_busy, a_degen;
  logic [31:0] a_seed_x;
  logic [47:0] a_seed_gain;
  logic [7:0]  a_out_data;
  // u2: CHANNELS=2, N_WARMUP=1
  logic b_seed_valid, b_seed_ready, b_out_valid, b_out_ready, b_busy, b_degen;
  logic [63:0] b_seed_x;
  logic [95:0] b_seed_gain;
  logic [7:0]  b_out_data;
  // u3: CHANNELS=3, N_WARMUP=64
  logic c_seed_valid, c_seed_ready, c_out_valid, c_out_ready, c_busy, c_degen;
  logic [95:0]  c_seed_x;
  logic [143:0] c_seed_gain;
  logic [7:0]   c_out_data;

  sawtooth_keystream #(.FRAC_W(32), .GAIN_W(16), .CHANNELS(1), .N_WARMUP(1), .OUT_W(8)) u1 (
    .clk(clk), .reset(rst), .seed_valid(a_seed_valid), .seed_ready(a_seed_ready),
    .seed_x(a_seed_x), .seed_gain(a_seed_gain), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .busy(a_busy), .degen(a_degen));

  sawtooth_keystream #(.FRAC_W(32), .GAIN_W(16), .CHANNELS(2), .N_WARMUP(1), .OUT_W(8)) u2 (
    .clk(clk), .reset(rst), .seed_valid(b_seed_valid), .seed_ready(b_seed_ready),
    .seed_x(b_seed_x), .seed_gain(b_seed_gain), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .busy(b_busy), .degen(b_degen));

  sawtooth_keystream #(.FRAC_W(32), .GAIN_W(16), .CHANNELS(3), .N_WARMUP(64), .OUT_W(8)) u3 (
    .clk(clk), .reset(rst), .seed_valid(c_seed_valid), .seed_ready(c_seed_ready),
    .seed_x(c_seed_x), .seed_gain(c_seed_gain), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .busy(c_busy), .degen(c_degen));

  // ---------------- reference model (one instance modelled at a time) ----------------
  logic [31:0] mx [3];
  logic [47:0] mg [3];
  logic [15:0] ml;
  int          m_phase;   // 0 idle, 1 warming up, 2 producing words
  int          m_left;    // warm-up iterations still to run

  function automatic logic [31:0] map_step(input logic [31:0] x, input logic [47:0] g);
    logic [79:0] p;
    p = 80'(x) * 80'(g);
    return p[63:32];  // frac(g*x) in Q0.32, truncated
  endfunction

  function automatic logic [15:0] rot_left(input logic [15:0] v, input int n);
    logic [31:0] d;
    d = {v, v} << (n % 16);
    return d[31:16];
  endfunction

  task automatic model_reset;
    for (int c = 0; c < 3; c++) begin
      mx[c] = '0;
      mg[c] = '0;
    end
    ml      = 16'hACE1;
    m_phase = 0;
    m_left  = 0;
  endtask

  task automatic model_iter(input int nch, input bit run);
    logic [31:0] nx;
    for (int c = 0; c < nch; c++) begin
      nx = map_step(mx[c], mg[c]);
      if (PERTURB && run) nx[15:0] = nx[15:0] ^ rot_left(ml, c);
      mx[c] = nx;
    end
    if (run) ml = {ml[14:0], ^(ml & 16'hB400)};
  endtask

  task automatic model_edge(input int nch, input int nw, input bit sv,
                            input logic [95:0] sx, input logic [143:0] sg, input bit ordy);
    if (sv && m_phase != 1) begin
      for (int c = 0; c < nch; c++) begin
        mx[c] = sx[c*32 +: 32];
        mg[c] = sg[c*48 +: 48];
      end
      ml      = 16'hACE1;
      m_left  = nw;
      m_phase = (nw == 0) ? 2 : 1;
    end else if (m_phase == 1) begin
      model_iter(nch, 1'b0);
      m_left = m_left - 1;
      if (m_left == 0) m_phase = 2;
    end else if (m_phase == 2 && ordy) begin
      model_iter(nch, 1'b1);
    end
  endtask

  function automatic logic [7:0] model_word(input int nch);
    logic [7:0] w;
    w = '0;
    for (int c = 0; c < nch; c++) w = w ^ mx[c][31:24];
    return w;
  endfunction

  function automatic logic model_degen(input int nch);
    logic z;
    z = 1'b0;
    for (int c = 0; c < nch; c++) if (mx[c] == 32'd0) z = 1'b1;
    return (m_phase == 2) && z;
  endfunction

  function automatic logic [11:0] model_obs(input int nch);
    return {m_phase == 2, model_word(nch), model_degen(nch), m_phase == 1, m_phase != 1};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    a_seed_valid = 0; a_out_ready = 0; a_seed_x = '0; a_seed_gain = '0;
    b_seed_valid = 0; b_out_ready = 0; b_seed_x = '0; b_seed_gain = '0;
    c_seed_valid = 0; c_out_ready = 0; c_seed_x = '0; c_seed_gain = '0;
    tick;
    tick;
    rst = 1'b0;
    model_reset;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    logic [11:0] obs;
    do_reset;
    obs = {a_seed_ready, a_out_valid, a_out_data, a_busy, a_degen};
    tests_run++;
    if (obs !== 12'b1_0_00000000_0_0) begin
      tests_failed++; $display("FAIL reset_u1: got %h want %h", obs, 12'b1_0_00000000_0_0);
    end
    obs = {b_seed_ready, b_out_valid, b_out_data, b_busy, b_degen};
    tests_run++;
    if (obs !== 12'b1_0_00000000_0_0) begin
      tests_failed++; $display("FAIL reset_u2: got %h want %h", obs, 12'b1_0_00000000_0_0);
    end
    obs = {c_seed_ready, c_out_valid, c_out_data, c_busy, c_degen};
    tests_run++;
    if (obs !== 12'b1_0_00000000_0_0) begin
      tests_failed++; $display("FAIL reset_u3: got %h want %h", obs, 12'b1_0_00000000_0_0);
    end
  endtask

  task automatic run_u1(input string name, input logic [31:0] x, input logic [47:0] g);
    logic [11:0] obs, exp;
    do_reset;
    a_seed_x = x; a_seed_gain = g; a_seed_valid = 1'b1; a_out_ready = 1'b1;
    tick;
    model_edge(1, 1, a_seed_valid, 96'(a_seed_x), 144'(a_seed_gain), a_out_ready);
    a_seed_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      obs = {a_out_valid, a_out_data, a_degen, a_busy, a_seed_ready};
      exp = model_obs(1);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++; $display("FAIL %s step %0d: got %h want %h", name, i, obs, exp);
      end
      tick;
      model_edge(1, 1, a_seed_valid, 96'(a_seed_x), 144'(a_seed_gain), a_out_ready);
    end
  endtask

  task automatic test_fixed_point;
    run_u1("fixed_point", 32'h8000_0000, 48'h0003_0000_0000);
  endtask

  task automatic test_collapse;
    run_u1("collapse", 32'h4000_0000, 48'h0002_0000_0000);
  endtask

  task automatic test_stall_reseed;
    logic [11:0] obs, exp;
    do_reset;
    b_seed_x    = {32'h4000_0000, 32'h8000_0000};
    b_seed_gain = {48'h0003_0000_0000, 48'h0003_0000_0000};
    b_seed_valid = 1'b1; b_out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i == 6)  b_out_ready = 1'b0;
      if (i == 11) b_out_ready = 1'b1;
      tick;
      model_edge(2, 1, b_seed_valid, 96'(b_seed_x), 144'(b_seed_gain), b_out_ready);
      b_seed_valid = (i == 13);  // reseed while RUN with out_ready high
      obs = {b_out_valid, b_out_data, b_degen, b_busy, b_seed_ready};
      exp = model_obs(2);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++; $display("FAIL stall_reseed step %0d: got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_random;
    logic [11:0] obs, exp;
    do_reset;
    for (int i = 0; i < 400; i++) begin
      b_seed_valid = (i == 0) || ($urandom_range(0, 15) == 0);
      for (int c = 0; c < 2; c++) begin
        b_seed_x[c*32 +: 32] = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom);
        b_seed_gain[c*48 +: 48] = ($urandom_range(0, 9) == 0) ? 48'd0 :
                                  {16'($urandom_range(0, 7)), 32'($urandom)};
      end
      b_out_ready = ($urandom_range(0, 3) != 0);
      tick;
      model_edge(2, 1, b_seed_valid, 96'(b_seed_x), 144'(b_seed_gain), b_out_ready);
      obs = {b_out_valid, b_out_data, b_degen, b_busy, b_seed_ready};
      exp = model_obs(2);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++; $display("FAIL random cycle %0d: got %h want %h", i, obs, exp);
      end
    end
    b_seed_valid = 1'b0;
  endtask

  task automatic test_warmup_timing;
    logic [11:0] obs, exp;
    logic [2:0]  st;
    do_reset;
    for (int c = 0; c < 3; c++) begin
      c_seed_x[c*32 +: 32]    = $urandom;
      c_seed_gain[c*48 +: 48] = {16'($urandom_range(1, 9)), 32'($urandom)};
    end
    c_seed_valid = 1'b1; c_out_ready = 1'b0;
    tick;  // edge T
    model_edge(3, 64, c_seed_valid, c_seed_x, c_seed_gain, c_out_ready);
    c_seed_valid = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      st = {c_busy, c_out_valid, c_seed_ready};
      tests_run++;
      if (st !== 3'b100) begin
        tests_failed++; $display("FAIL warmup_busy before edge T+%0d: got %b want 100", k, st);
      end
      tick;
      model_edge(3, 64, c_seed_valid, c_seed_x, c_seed_gain, c_out_ready);
    end
    st = {c_busy, c_out_valid, c_seed_ready};
    tests_run++;
    if (st !== 3'b011) begin
      tests_failed++; $display("FAIL warmup_done after T+64: got %b want 011", st);
    end
    for (int i = 0; i < 8; i++) begin
      obs = {c_out_valid, c_out_data, c_degen, c_busy, c_seed_ready};
      exp = model_obs(3);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++; $display("FAIL warmup_words %0d: got %h want %h", i, obs, exp);
      end
      c_out_ready = $urandom_range(0, 1);
      tick;
      model_edge(3, 64, c_seed_valid, c_seed_x, c_seed_gain, c_out_ready);
    end
    // reseed, then reset lands on warm-up edge 10
    c_seed_x[31:0] = $urandom;
    c_seed_valid = 1'b1;
    tick;
    model_edge(3, 64, c_seed_valid, c_seed_x, c_seed_gain, c_out_ready);
    c_seed_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick;
      model_edge(3, 64, c_seed_valid, c_seed_x, c_seed_gain, c_out_ready);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    model_reset;
    st = {c_seed_ready, c_out_valid, c_busy};
    tests_run++;
    if (st !== 3'b100) begin
      tests_failed++; $display("FAIL midwarm_reset: got %b want 100", st);
    end
    c_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      model_edge(3, 64, c_seed_valid, c_seed_x, c_seed_gain, c_out_ready);
      obs = {c_out_valid, c_out_data, c_degen, c_busy, c_seed_ready};
      exp = model_obs(3);
      tests_run++;
      if (obs !== exp) begin
        tests_failed++; $display("FAIL post_reset_idle %0d: got %h want %h", i, obs, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset;
    test_fixed_point;
    test_collapse;
    test_stall_reseed;
    test_random;
    test_warmup_timing;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sawtooth_keystream.md
# sawtooth_keystream

Multi-channel fixed-point sawtooth chaotic map generator for the image-encryption datapath. Each channel iterates x(n+1) = frac(g · x(n)), where g = 1/epsilon is the channel gain. The block discards a configurable warm-up transient, then emits one keystream word per accepted handshake: the XOR of the top bits of every channel state. It sits between seed/key expansion and the pixel XOR/permutation stage.

## Interface
- FRAC_W, 32, fraction bits of each state; states are unsigned Q0.FRAC_W in [0,1)
- GAIN_W, 16, integer bits of each gain; gains are unsigned QGAIN_W.FRAC_W
- CHANNELS, 2, number of independent map instances (≥1)
- N_WARMUP, 64, iterations discarded after each seed load (≥0)
- OUT_W, 8, keystream word width (≤FRAC_W)

Ports:
- clk  in  1  clock; all logic is rising-edge
- reset  in  1  synchronous, active-high reset
- seed_valid  in  1  seed bundle valid
- seed_ready  out  1  block can accept a seed
- seed_x  in  CHANNELS·FRAC_W  initial states; channel c occupies bits [c·FRAC_W +: FRAC_W]
- seed_gain  in  CHANNELS·(GAIN_W+FRAC_W)  gains; channel c occupies bits [c·(GAIN_W+FRAC_W) +: GAIN_W+FRAC_W]
- out_valid  out  1  keystream word valid
- out_ready  in  1  consumer accepts the word
- out_data  out  OUT_W  XOR over c of x_c[FRAC_W-1 -: OUT_W]
- busy  out  1  high in WARMUP
- degen  out  1  high in RUN when any channel state equals 0

## Operation
- FSM states: IDLE, WARMUP, RUN.
- Reset: state IDLE; all x_c, g_c and the warm-up counter are 0. Outputs after reset: seed_ready=1, out_valid=0, out_data=0, busy=0, degen=0.
- seed_ready = 1 in IDLE and RUN, 0 in WARMUP.
- Seed accept (seed_valid && seed_ready): load x_c and g_c; load counter with N_WARMUP-1; go to WARMUP. If N_WARMUP=0, go directly to RUN.
- Iteration, per channel, in parallel:
  - form the full product p = x_c · g_c, of width 2·FRAC_W+GAIN_W;
  - set x_c <= p[2·FRAC_W-1:FRAC_W], i.e. integer part dropped, fraction truncated.
- WARMUP: iterate every cycle; decrement the counter; when the counter is 0 at an edge, iterate and go to RUN.
- RUN:
  - out_valid=1.
  - out_data and degen are combinational from the state registers.
  - Iterate only on out_valid && out_ready.
  - Otherwise hold x_c, so out_data is stable under stall.
- Reseed in RUN: seed accept has priority. If out_ready is also high on that edge, the presented word counts as consumed; the states load the seed, not the iterate result.
- Reset mid-operation (any state): returns to IDLE within that edge; no further output.
- Gain 0 or state 0 yields state 0 (fixed point); this is legal and flagged by degen.

## Timing
- Seed accepted at edge T.
  - N_WARMUP≥1: WARMUP occupies edges T+1..T+N_WARMUP; out_valid rises after edge T+N_WARMUP.
  - N_WARMUP=0: out_valid rises after edge T.
- Throughput: one word per cycle while out_ready=1.
- One iteration per cycle, with a single-cycle multiply-and-truncate per channel.
- No output latency beyond the state register.

## Configuration
- SAWTOOTH_PERTURB_EN defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) resets and reloads on seed accept to 16'hACE1.
  - It steps once per RUN iteration.
  - On each RUN iteration, each x_c's next value has its low 16 bits XORed with the LFSR value. Channel c uses the LFSR rotated left by c.
  - This breaks finite-precision cycles and escapes the zero fixed point.
  - WARMUP iterations are not perturbed.
- Not defined: no LFSR; the pure map; zero states persist.

## Test plan
All scenarios use FRAC_W=32, GAIN_W=16, OUT_W=8, and are built without SAWTOOTH_PERTURB_EN unless stated.
- CHANNELS=1, N_WARMUP=1, x=32'h80000000 (0.5), g=3.0 (48'h0003_00000000) -> out_data=8'h80 on every accepted word; degen=0.
- CHANNELS=1, N_WARMUP=1, x=32'h40000000, g=2.0 -> first word 8'h80, then 8'h00 with degen=1 on all later words.
- CHANNELS=2, N_WARMUP=1, ch0 x=0.5 g=3, ch1 x=0.25 g=3 -> words alternate 8'h40, 8'hC0.
  - Hold out_ready=0 for 5 cycles -> out_data held, states unchanged.
  - Reseed in RUN with out_ready=1 -> busy for 1 cycle, sequence restarts at 8'h40.
- N_WARMUP=64: seed at edge T -> busy high edges T+1..T+64; out_valid first high after T+64.
  - Assert reset at warm-up edge 10 -> IDLE, out_valid=0, seed_ready=1 next cycle.
- Built with SAWTOOTH_PERTURB_EN, case of the second scenario -> degen deasserts within 3 words; state never stays 0 for 2 consecutive words.
